// File: rtl/ecc_result_serializer.sv
// rtl/ecc_result_serializer.sv - serializes the ECC kP affine result (x, y) into a framed nibble stream
// Optional macro SERIALIZER_DBUF_EN adds a one-entry result buffer for zero-bubble back-to-back streams.
module ecc_result_serializer #(
    parameter int DATA_W = 32,
    parameter int NIB_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_x,
    input  logic [DATA_W-1:0] i_y,
    input  logic              i_hold,
    output logic              o_ready,
    output logic [NIB_W-1:0]  o_kP,
    output logic              o_kP_valid,
    output logic              o_first,
    output logic              o_last,
    output logic              o_overrun
);

    localparam int SR_W       = 2 * DATA_W;
    localparam int COORD_NIBS = DATA_W / NIB_W;
    localparam int CNT_W      = $clog2(COORD_NIBS);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(COORD_NIBS - 1);
    localparam logic [CNT_W-1:0] CNT_PRELAST = CNT_W'(COORD_NIBS - 2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT_X = 2'd1,
        SHIFT_Y = 2'd2
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_d;
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_d;
    logic [NIB_W-1:0]  kp_d;
    logic              first_d;
    logic              last_d;
    logic              valid_d;

    logic              accept;
    logic              consume;
    logic              end_y;
    logic              load_in;
    logic              load_buf;
    logic              load;
    logic [SR_W-1:0]   load_data;

    assign accept  = i_valid && o_ready;
    assign consume = (state != IDLE) && !i_hold;
    assign end_y   = (state == SHIFT_Y) && (cnt == CNT_LAST) && !i_hold;
    // Direct load: from IDLE, or (buffered build only) on the last-nibble consume edge.
    assign load_in = accept && ((state == IDLE) || end_y);
    assign load    = load_in || load_buf;

`ifdef SERIALIZER_DBUF_EN
    logic [SR_W-1:0] buf_data;
    logic            buf_full;
    logic            buf_fill;

    assign o_ready   = !buf_full;
    assign load_buf  = end_y && buf_full;
    assign buf_fill  = accept && (state != IDLE) && !end_y;
    assign load_data = load_buf ? buf_data : {i_x, i_y};

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            buf_data <= '0;
            buf_full <= 1'b0;
        end else if (load_buf) begin
            buf_full <= 1'b0;
        end else if (buf_fill) begin
            buf_data <= {i_x, i_y};
            buf_full <= 1'b1;
        end
    end
`else
    assign o_ready   = (state == IDLE);
    assign load_buf  = 1'b0;
    assign load_data = {i_x, i_y};
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (load) begin
                    state_d = SHIFT_X;
                end
            end
            SHIFT_X: begin
                if (consume && (cnt == CNT_LAST)) begin
                    state_d = SHIFT_Y;
                end
            end
            SHIFT_Y: begin
                if (end_y) begin
                    state_d = load ? SHIFT_X : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered stream outputs; a load takes priority over returning to IDLE.
    always_comb begin
        sr_d    = sr;
        cnt_d   = cnt;
        kp_d    = o_kP;
        first_d = o_first;
        last_d  = o_last;
        valid_d = o_kP_valid;
        if (load) begin
            sr_d    = {load_data[SR_W-NIB_W-1:0], {NIB_W{1'b0}}};
            kp_d    = load_data[SR_W-1 -: NIB_W];
            cnt_d   = '0;
            first_d = 1'b1;
            last_d  = 1'b0;
            valid_d = 1'b1;
        end else if (end_y) begin
            sr_d    = '0;
            kp_d    = '0;
            cnt_d   = '0;
            first_d = 1'b0;
            last_d  = 1'b0;
            valid_d = 1'b0;
        end else if (consume) begin
            sr_d    = {sr[SR_W-NIB_W-1:0], {NIB_W{1'b0}}};
            kp_d    = sr[SR_W-1 -: NIB_W];
            cnt_d   = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            first_d = 1'b0;
            last_d  = (state == SHIFT_Y) && (cnt == CNT_PRELAST);
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            sr         <= '0;
            cnt        <= '0;
            o_kP       <= '0;
            o_first    <= 1'b0;
            o_last     <= 1'b0;
            o_kP_valid <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            sr         <= sr_d;
            cnt        <= cnt_d;
            o_kP       <= kp_d;
            o_first    <= first_d;
            o_last     <= last_d;
            o_kP_valid <= valid_d;
            o_overrun  <= o_overrun | (i_valid & ~o_ready);
        end
    end

endmodule

// File: tb/tb_ecc_result_serializer.sv
// tb/tb_ecc_result_serializer.sv - directed bench for ecc_result_serializer
module tb_ecc_result_serializer;

`ifdef SERIALIZER_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_x = '0;
    logic [31:0] i_y = '0;
    logic        i_hold = 1'b0;
    logic        o_ready;
    logic [3:0]  o_kP;
    logic        o_kP_valid;
    logic        o_first;
    logic        o_last;
    logic        o_overrun;

    int total = 0;
    int bad   = 0;

    ecc_result_serializer dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .i_x        (i_x),
        .i_y        (i_y),
        .i_hold     (i_hold),
        .o_ready    (o_ready),
        .o_kP       (o_kP),
        .o_kP_valid (o_kP_valid),
        .o_first    (o_first),
        .o_last     (o_last),
        .o_overrun  (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] x, input logic [31:0] y);
        i_valid = 1'b1;
        i_x     = x;
        i_y     = y;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic expect_stream(input logic [63:0] d, input string tag, input bit chk_rdy);
        for (int n = 0; n < 16; n++) begin
            check({tag, "_kp"}, o_kP, d[63-4*n -: 4]);
            check({tag, "_valid"}, o_kP_valid, 1'b1);
            check({tag, "_first"}, o_first, (n == 0));
            check({tag, "_last"}, o_last, (n == 15));
            if (chk_rdy) check({tag, "_ready"}, o_ready, DBUF);
            tick();
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_kp"}, o_kP, 4'h0);
        check({tag, "_valid"}, o_kP_valid, 1'b0);
        check({tag, "_first"}, o_first, 1'b0);
        check({tag, "_last"}, o_last, 1'b0);
        check({tag, "_ready"}, o_ready, 1'b1);
    endtask

    logic [63:0]  basic  = 64'h12345678_9ABCDEF0;
    logic [63:0]  fresh  = 64'h00000003_0000000A;
    logic [127:0] two    = 128'h12345678_9ABCDEF0_FFFFFFFF_00000000;
    int idx;

    initial begin
        // reset
        tick();
        tick();
        check_idle("rst");
        check("rst_ovr", o_overrun, 1'b0);
        i_rst = 1'b1;
        tick();

        // basic order
        offer(32'h12345678, 32'h9ABCDEF0);
        expect_stream(basic, "basic", 1'b1);
        check_idle("basic_end");
        tick();

        // stall: hold during cycles +6..+8 while nibble 5 shows
        offer(32'h12345678, 32'h9ABCDEF0);
        for (int c = 1; c <= 19; c++) begin
            idx = (c <= 6) ? c - 1 : (c <= 9) ? 5 : c - 4;
            check("stall_kp", o_kP, basic[63-4*idx -: 4]);
            check("stall_valid", o_kP_valid, 1'b1);
            check("stall_last", o_last, (c == 19));
            i_hold = (c >= 6) && (c <= 8);
            tick();
        end
        i_hold = 1'b0;
        check_idle("stall_end");
        tick();

        // hold on the o_last cycle for two cycles
        offer(32'h12345678, 32'h9ABCDEF0);
        for (int c = 1; c < 16; c++) tick();
        check("ehold_last16", o_last, 1'b1);
        i_hold = 1'b1;
        tick();
        check("ehold_last17", o_last, 1'b1);
        check("ehold_valid17", o_kP_valid, 1'b1);
        check("ehold_kp17", o_kP, 4'h0);
        tick();
        check("ehold_last18", o_last, 1'b1);
        check("ehold_valid18", o_kP_valid, 1'b1);
        i_hold = 1'b0;
        tick();
        check_idle("ehold_end");

        // hold in IDLE does not block an accept
        i_hold = 1'b1;
        offer(32'h12345678, 32'h9ABCDEF0);
        check("idlehold_valid", o_kP_valid, 1'b1);
        check("idlehold_first", o_first, 1'b1);
        check("idlehold_kp", o_kP, 4'h1);
        i_hold = 1'b0;
        for (int c = 1; c <= 16; c++) tick();
        check_idle("idlehold_end");

        // reset mid-stream in cycle +6, then a fresh result
        offer(32'h12345678, 32'h9ABCDEF0);
        for (int c = 1; c < 6; c++) tick();
        i_rst = 1'b0;
        tick();
        check_idle("midrst");
        i_rst = 1'b1;
        offer(32'h00000003, 32'h0000000A);
        expect_stream(fresh, "fresh", 1'b0);
        check_idle("fresh_end");
        tick();

`ifdef SERIALIZER_DBUF_EN
        // second result buffered in cycle +3, third offer in cycle +5 overruns
        offer(32'h12345678, 32'h9ABCDEF0);
        for (int c = 1; c <= 32; c++) begin
            check("dbuf_kp", o_kP, two[127-4*(c-1) -: 4]);
            check("dbuf_valid", o_kP_valid, 1'b1);
            check("dbuf_first", o_first, (c == 1) || (c == 17));
            check("dbuf_last", o_last, (c == 16) || (c == 32));
            if (c == 3) check("dbuf_ready3", o_ready, 1'b1);
            if (c == 4) check("dbuf_ready4", o_ready, 1'b0);
            if (c == 6) check("dbuf_ovr6", o_overrun, 1'b1);
            if (c == 4) check("dbuf_ovr4", o_overrun, 1'b0);
            i_valid = (c == 3) || (c == 5);
            i_x     = (c == 3) ? 32'hFFFFFFFF : 32'h11111111;
            i_y     = (c == 3) ? 32'h00000000 : 32'h22222222;
            tick();
        end
        i_valid = 1'b0;
        check_idle("dbuf_end");
        check("dbuf_ovr_end", o_overrun, 1'b1);
`else
        // overrun: a result offered in cycle +4 is dropped
        offer(32'h12345678, 32'h9ABCDEF0);
        for (int c = 1; c <= 16; c++) begin
            check("ovr_kp", o_kP, basic[63-4*(c-1) -: 4]);
            check("ovr_last", o_last, (c == 16));
            if (c == 4) check("ovr_before", o_overrun, 1'b0);
            if (c == 5) check("ovr_set", o_overrun, 1'b1);
            i_valid = (c == 4);
            i_x     = 32'hDEADBEEF;
            i_y     = 32'hCAFEF00D;
            tick();
        end
        i_valid = 1'b0;
        check_idle("ovr_end");
        tick();
        tick();
        check("ovr_sticky", o_overrun, 1'b1);
        check("ovr_no_stream", o_kP_valid, 1'b0);
`endif
        i_rst = 1'b0;
        tick();
        check("final_ovr_clr", o_overrun, 1'b0);
        i_rst = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
